// File: rtl/serial_nibble_loader_if.sv
// Handshake/data bundle between a serial bit source and serial_nibble_loader.
//   i_valid, i_bit, i_clear : source -> loader (bit stream and partial-word abort)
//   o_ready                 : loader -> source (bit accepted when i_valid && o_ready)
//   o_en, o_d               : loader -> downstream register (load strobe and word)
//   o_bitcnt, o_words       : loader status (partial bit count, completed words mod 256)
interface serial_nibble_loader_if #(
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned CNT_W   = $clog2(WIDTH);
  localparam int unsigned WORDS_W = 8;

  logic               i_valid;
  logic               i_bit;
  logic               i_clear;
  logic               o_ready;
  logic               o_en;
  logic [WIDTH-1:0]   o_d;
  logic [CNT_W-1:0]   o_bitcnt;
  logic [WORDS_W-1:0] o_words;

  modport master (
    output i_valid, i_bit, i_clear,
    input  o_ready, o_en, o_d, o_bitcnt, o_words
  );

  modport slave (
    input  i_valid, i_bit, i_clear,
    output o_ready, o_en, o_d, o_bitcnt, o_words
  );
endinterface

// File: rtl/serial_nibble_loader.sv
// Serial-to-parallel loader: accepts one bit per cycle under valid/ready, assembles
// WIDTH bits, then presents the word on o_d with a one-cycle o_en strobe for the
// downstream enabled register.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : serial_nibble_loader_if slave side (handshake, word, strobe, status)
module serial_nibble_loader #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  serial_nibble_loader_if.slave bus
);
  localparam int unsigned CNT_W   = $clog2(WIDTH);
  localparam int unsigned WORDS_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    STROBE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORDS_W-1:0] words_q, words_d;
  logic               en_q, en_d;
  logic               ready_q, ready_d;
  logic               accept_c;
  logic [WIDTH-1:0]   shifted_c;

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      words_q <= '0;
      en_q    <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
      en_q    <= en_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic; o_en/o_ready are registered copies of the next-state decode
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    words_d  = words_q;
    accept_c = bus.i_valid && ready_q;

    if (MSB_FIRST) begin
      shifted_c = {sr_q[WIDTH-2:0], bus.i_bit};
    end else begin
      shifted_c = {bus.i_bit, sr_q[WIDTH-1:1]};
    end

    case (state_q)
      IDLE: begin
        if (bus.i_clear) begin
          sr_d  = '0;
          cnt_d = '0;
        end else if (accept_c) begin
          sr_d    = shifted_c;
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.i_clear) begin
          sr_d    = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (accept_c) begin
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            // Last bit of the word: publish it and open the strobe cycle
            d_d     = shifted_c;
            sr_d    = '0;
            cnt_d   = '0;
            words_d = words_q + WORDS_W'(1);
            state_d = STROBE;
          end else begin
            sr_d  = shifted_c;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      STROBE: begin
        // Strobe always completes; a clear here only re-zeroes the partial state
        if (bus.i_clear) begin
          sr_d  = '0;
          cnt_d = '0;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    en_d    = (state_d == STROBE);
    ready_d = (state_d != STROBE);
  end

  assign bus.o_ready  = ready_q;
  assign bus.o_en     = en_q;
  assign bus.o_d      = d_q;
  assign bus.o_bitcnt = cnt_q;
  assign bus.o_words  = words_q;
endmodule

// File: tb/tb_serial_nibble_loader.sv
// Bench for serial_nibble_loader: an MSB-first and an LSB-first instance share one
// stimulus stream; a queue-based model is compared on every falling edge, and
// directed scenarios pin literal values.
module tb_serial_nibble_loader;
  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  serial_nibble_loader_if #(.WIDTH(W)) bus_m ();
  serial_nibble_loader_if #(.WIDTH(W)) bus_l ();

  serial_nibble_loader #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_m)
  );
  serial_nibble_loader #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_l)
  );

  always #5 clk = ~clk;

  // Downstream enabled registers fed by each loader
  logic [W-1:0] q_m, q_l;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_m <= '0;
      q_l <= '0;
    end else begin
      if (bus_m.o_en) q_m <= bus_m.o_d;
      if (bus_l.o_en) q_l <= bus_l.o_d;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: accepted bits held in a queue, word built arithmetically
  bit           part[$];
  bit           in_strobe = 1'b0;
  int           exp_words = 0;
  logic [W-1:0] exp_d_m = '0;
  logic [W-1:0] exp_d_l = '0;

  task automatic model_reset();
    part.delete();
    in_strobe = 1'b0;
    exp_words = 0;
    exp_d_m   = '0;
    exp_d_l   = '0;
  endtask

  task automatic model_edge(input bit v, input bit b, input bit c);
    int wm, wl;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (in_strobe) begin
      in_strobe = 1'b0;
      part.delete();
    end else if (c) begin
      part.delete();
    end else if (v) begin
      part.push_back(b);
      if (part.size() == W) begin
        wm = 0;
        wl = 0;
        for (int i = 0; i < W; i++) begin
          wm += int'(part[i]) * (1 << (W - 1 - i));
          wl += int'(part[i]) * (1 << i);
        end
        exp_d_m   = W'(wm);
        exp_d_l   = W'(wl);
        exp_words = (exp_words + 1) % 256;
        part.delete();
        in_strobe = 1'b1;
      end
    end
  endtask

  // One clock: drive inputs, step the model on the edge, settle past the edge
  task automatic cyc(input bit v, input bit b, input bit c);
    bus_m.i_valid = v; bus_m.i_bit = b; bus_m.i_clear = c;
    bus_l.i_valid = v; bus_l.i_bit = b; bus_l.i_clear = c;
    @(posedge clk);
    model_edge(v, b, c);
    #1;
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check({tag, "_rst_d"}, 32'(bus_m.o_d), 32'(0));
    check({tag, "_rst_cnt"}, 32'(bus_m.o_bitcnt), 32'(0));
    check({tag, "_rst_words"}, 32'(bus_m.o_words), 32'(0));
    check({tag, "_rst_en"}, 32'(bus_m.o_en), 32'(0));
    check({tag, "_rst_ready"}, 32'(bus_m.o_ready), 32'(1));
    #3;
    rst_n = 1'b1;
  endtask

  // Per-cycle compare against the model, plus downstream capture check
  bit pend = 1'b0;
  always @(negedge clk) begin
    check("en_m", 32'(bus_m.o_en), 32'(in_strobe));
    check("ready_m", 32'(bus_m.o_ready), 32'(!in_strobe));
    check("bitcnt_m", 32'(bus_m.o_bitcnt), 32'(part.size()));
    check("words_m", 32'(bus_m.o_words), 32'(exp_words));
    check("d_m", 32'(bus_m.o_d), 32'(exp_d_m));
    check("en_l", 32'(bus_l.o_en), 32'(in_strobe));
    check("bitcnt_l", 32'(bus_l.o_bitcnt), 32'(part.size()));
    check("words_l", 32'(bus_l.o_words), 32'(exp_words));
    check("d_l", 32'(bus_l.o_d), 32'(exp_d_l));
    if (pend && rst_n) begin
      check("q_m", 32'(q_m), 32'(exp_d_m));
      check("q_l", 32'(q_l), 32'(exp_d_l));
    end
    pend = in_strobe && rst_n;
  end

  initial begin
    bit s4 [9];
    int strobe_at [$];
    logic [W-1:0] strobe_w [$];
    bit rb;

    cyc(0, 0, 0);
    do_reset("init");

    // 1/2: 1,0,1,0 -> MSB 1010, LSB 0101, then a long gap holds the word
    cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 0, 0);
    check("t1_en", 32'(bus_m.o_en), 32'(1));
    check("t1_d", 32'(bus_m.o_d), 32'(4'b1010));
    check("t1_ready", 32'(bus_m.o_ready), 32'(0));
    check("t2_d_lsb", 32'(bus_l.o_d), 32'(4'b0101));
    cyc(0, 0, 0);
    check("t1_en_off", 32'(bus_m.o_en), 32'(0));
    check("t1_words", 32'(bus_m.o_words), 32'(1));
    repeat (10) cyc(0, 0, 0);
    check("t2_hold", 32'(bus_l.o_d), 32'(4'b0101));
    check("t2_en", 32'(bus_l.o_en), 32'(0));

    // 3: clear with valid discards the partial word
    do_reset("t3");
    cyc(1, 1, 0); cyc(1, 1, 0);
    check("t3_cnt2", 32'(bus_m.o_bitcnt), 32'(2));
    cyc(1, 1, 1);
    check("t3_cnt0", 32'(bus_m.o_bitcnt), 32'(0));
    check("t3_no_en", 32'(bus_m.o_en), 32'(0));
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 1, 0);
    check("t3_no_en2", 32'(bus_m.o_en), 32'(0));
    cyc(1, 1, 0);
    check("t3_en", 32'(bus_m.o_en), 32'(1));
    check("t3_d", 32'(bus_m.o_d), 32'(4'b0011));
    check("t3_words", 32'(bus_m.o_words), 32'(1));

    // 4: valid held across STROBE; the fifth bit is dropped
    do_reset("t4");
    s4 = '{1, 1, 1, 1, 1, 0, 1, 1, 0};
    for (int i = 0; i < 9; i++) begin
      cyc(1, s4[i], 0);
      if (bus_m.o_en) begin
        strobe_at.push_back(i);
        strobe_w.push_back(bus_m.o_d);
      end
    end
    cyc(0, 0, 0);
    check("t4_nstrobes", 32'(strobe_at.size()), 32'(2));
    if (strobe_at.size() == 2) begin
      check("t4_w0", 32'(strobe_w[0]), 32'(4'b1111));
      check("t4_w1", 32'(strobe_w[1]), 32'(4'b0110));
      check("t4_gap", 32'(strobe_at[1] - strobe_at[0]), 32'(5));
    end

    // 5: reset mid-word clears everything, next word assembles cleanly
    do_reset("t5a");
    cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
    cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 1, 0);
    check("t5_pre_d", 32'(bus_m.o_d), 32'(4'b1100));
    do_reset("t5b");
    cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 1, 0);
    check("t5_en", 32'(bus_m.o_en), 32'(1));
    check("t5_d", 32'(bus_m.o_d), 32'(4'b1001));
    cyc(0, 0, 0);

    // Mixed traffic with gaps and occasional clears, checked by the model
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 15) == 0));
    end

    // 6: 257 words wrap the counter to 1
    do_reset("t6");
    for (int n = 0; n < 257; n++) begin
      for (int k = 0; k < W; k++) begin
        rb = 1'($urandom_range(0, 1));
        cyc(1, rb, 0);
      end
      cyc(0, 0, 0);
    end
    check("t6_wrap_m", 32'(bus_m.o_words), 32'(1));
    check("t6_wrap_l", 32'(bus_l.o_words), 32'(1));
    cyc(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
